// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the fetch/data memory bus arbiter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mem_bus_arbiter_pkg;

    // Arbiter sequencing states
    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_REQ  = 2'd1;
    localparam logic [1:0] ARB_RESP = 2'd2;

    // Requester identifiers carried on bus_req_id
    localparam logic ARB_ID_IF  = 1'b0;
    localparam logic ARB_ID_MEM = 1'b1;

    // Default response timeout in cycles spent waiting in RESP
    localparam int ARB_TIMEOUT = 255;

endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Combinational grant selection between fetch and data requesters.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller qualifies grants with its own idle state.
// Ports: if_vld_i/mem_vld_i requester valids, last_grant_i previous winner,
//        grant_if_o/grant_mem_o one-hot (or zero) grant.
// Build option: MEM_ARB_RR_EN selects round-robin instead of data-first priority.
module arb_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic if_vld_i,
    input  logic mem_vld_i,
    input  logic last_grant_i,
    output logic grant_if_o,
    output logic grant_mem_o
);

`ifdef MEM_ARB_RR_EN
    // On a collision the side that did not win last time gets the bus.
    assign grant_mem_o = mem_vld_i & (~if_vld_i | (last_grant_i == ARB_ID_IF));
    assign grant_if_o  = if_vld_i & ~grant_mem_o;
`else
    // Data side always wins; previous winner is irrelevant here.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
    assign grant_mem_o = mem_vld_i;
    assign grant_if_o  = if_vld_i & ~mem_vld_i;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus port between instruction fetch and data requesters.
// Latency: best case 3 cycles from accept to response pulse (REQ, RESP, pulse).
// Backpressure: requesters see ready only in IDLE; bus_req_ready=0 holds REQ indefinitely,
//               RESP gives up after TIMEOUT_CYC cycles with an error pulse.
// Ports: if_req_*/if_resp_* fetch side, mem_req_*/mem_resp_* data side,
//        bus_req_*/bus_resp_* shared bus; bus_req_id tags the owner (0 fetch, 1 data).
// Build option: MEM_ARB_RR_EN enables round-robin arbitration (last_grant register).
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = ARB_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_resp_data,
    output logic                if_resp_err,
    input  logic                mem_req_valid,
    input  logic                mem_req_wen,
    input  logic [ADDR_W-1:0]   mem_req_addr,
    input  logic [DATA_W-1:0]   mem_req_wdata,
    input  logic [DATA_W/8-1:0] mem_req_wmask,
    output logic                mem_req_ready,
    output logic                mem_resp_valid,
    output logic [DATA_W-1:0]   mem_resp_rdata,
    output logic                mem_resp_err,
    output logic                bus_req_valid,
    input  logic                bus_req_ready,
    output logic                bus_req_wen,
    output logic [ADDR_W-1:0]   bus_req_addr,
    output logic [DATA_W-1:0]   bus_req_wdata,
    output logic [DATA_W/8-1:0] bus_req_wmask,
    output logic                bus_req_id,
    input  logic                bus_resp_valid,
    input  logic [DATA_W-1:0]   bus_resp_rdata
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              vld_q, vld_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic              id_q, id_d;
    logic              if_rv_q, if_rv_d, if_err_q, if_err_d;
    logic              mem_rv_q, mem_rv_d, mem_err_q, mem_err_d;
    logic [DATA_W-1:0] if_dat_q, if_dat_d, mem_dat_q, mem_dat_d;
    logic              last_grant;
    logic              grant_if, grant_mem, accept;
    logic              done, done_err;
    logic [DATA_W-1:0] done_dat;

`ifdef MEM_ARB_RR_EN
    logic lg_q, lg_d;
    assign last_grant = lg_q;
`else
    assign last_grant = ARB_ID_IF;
`endif

    arb_pick u_pick (
        .if_vld_i     (if_req_valid),
        .mem_vld_i    (mem_req_valid),
        .last_grant_i (last_grant),
        .grant_if_o   (grant_if),
        .grant_mem_o  (grant_mem)
    );

    // A request can only be taken while idle; reset overrides any accept.
    assign accept        = ~rst & (state_q == ARB_IDLE);
    assign if_req_ready  = accept & grant_if;
    assign mem_req_ready = accept & grant_mem;

    // Saturating increment so the counter can never wrap back to zero.
    assign cnt_inc = (cnt_q == CNT_W'(TIMEOUT_CYC)) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vld_d     = vld_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        id_d      = id_q;
        if_dat_d  = if_dat_q;
        mem_dat_d = mem_dat_q;
        done      = 1'b0;
        done_err  = 1'b0;
        done_dat  = '0;
`ifdef MEM_ARB_RR_EN
        lg_d      = lg_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (grant_if | grant_mem) begin
                    state_d = ARB_REQ;
                    vld_d   = 1'b1;
                    id_d    = grant_mem ? ARB_ID_MEM : ARB_ID_IF;
                    wen_d   = grant_mem & mem_req_wen;
                    addr_d  = grant_mem ? mem_req_addr : if_req_addr;
                    wdata_d = grant_mem ? mem_req_wdata : '0;
                    wmask_d = grant_mem ? mem_req_wmask : '0;
`ifdef MEM_ARB_RR_EN
                    lg_d    = grant_mem;
`endif
                end
            end
            ARB_REQ: begin
                if (bus_req_ready) begin
                    state_d = ARB_RESP;
                    vld_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            ARB_RESP: begin
                cnt_d = cnt_inc;
                // A real response in the final allowed cycle still wins over the timeout.
                if (bus_resp_valid) begin
                    done     = 1'b1;
                    done_dat = wen_q ? '0 : bus_resp_rdata;
                end else if (cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end
                if (done) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if_rv_d   = done & (id_q == ARB_ID_IF);
        mem_rv_d  = done & (id_q == ARB_ID_MEM);
        if_err_d  = if_rv_d & done_err;
        mem_err_d = mem_rv_d & done_err;
        if (if_rv_d) begin
            if_dat_d = done_dat;
        end
        if (mem_rv_d) begin
            mem_dat_d = done_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            cnt_q     <= '0;
            vld_q     <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            id_q      <= ARB_ID_IF;
            if_rv_q   <= 1'b0;
            if_err_q  <= 1'b0;
            if_dat_q  <= '0;
            mem_rv_q  <= 1'b0;
            mem_err_q <= 1'b0;
            mem_dat_q <= '0;
`ifdef MEM_ARB_RR_EN
            lg_q      <= ARB_ID_IF;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vld_q     <= vld_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            id_q      <= id_d;
            if_rv_q   <= if_rv_d;
            if_err_q  <= if_err_d;
            if_dat_q  <= if_dat_d;
            mem_rv_q  <= mem_rv_d;
            mem_err_q <= mem_err_d;
            mem_dat_q <= mem_dat_d;
`ifdef MEM_ARB_RR_EN
            lg_q      <= lg_d;
`endif
        end
    end

    assign bus_req_valid  = vld_q;
    assign bus_req_wen    = wen_q;
    assign bus_req_addr   = addr_q;
    assign bus_req_wdata  = wdata_q;
    assign bus_req_wmask  = wmask_q;
    assign bus_req_id     = id_q;
    assign if_resp_valid  = if_rv_q;
    assign if_resp_err    = if_err_q;
    assign if_resp_data   = if_dat_q;
    assign mem_resp_valid = mem_rv_q;
    assign mem_resp_err   = mem_err_q;
    assign mem_resp_rdata = mem_dat_q;

endmodule
